hazard_ctrl: RTL

Pipeline interlock and forwarding scheduler for the 5-stage core (IF/ID/EX/MEM/WB). Tracks destination registers in flight in EX, MEM and WB with a 3-slot scoreboard. Drives the decode-stage stall, inserts bubbles into EX, and produces registered operand-forwarding selects aligned to the EX stage. Also freezes the whole pipeline while data memory is busy.

---
 rtl/hazard_ctrl_if.sv | 22 ++
 rtl/hazard_ctrl.sv | 73 +++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-side handshake bundle between the core and the interlock/forwarding scheduler.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic [4:0]       id_rd_i;
  logic             id_mem_re_i;
  logic             mem_busy_i;
  logic             stall_o;
  logic             bubble_o;
  logic [1:0]       fwd_a_o;
  logic [1:0]       fwd_b_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_mem_re_i, mem_busy_i,
    input  stall_o, bubble_o, fwd_a_o, fwd_b_o, stall_cnt_o
  );
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_mem_re_i, mem_busy_i,
    output stall_o, bubble_o, fwd_a_o, fwd_b_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 3-slot scoreboard interlock and EX-aligned forwarding selects for the 5-stage core.
// FORWARDING_EN defined: load-use stall plus bypass; undefined: full RAW interlock, selects tied to 00.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } slot_t;
  slot_t ex, mem, wb, nxt;
  logic raw, hazard, issue, adv;
  logic [CNT_W-1:0] cnt;
  function automatic logic match(slot_t s, logic [4:0] rs);
    return s.v && s.rd == rs && rs != 5'd0;
  endfunction
`ifdef FORWARDING_EN
  assign raw = ex.ld & (match(ex, bus.id_rs1_i) | match(ex, bus.id_rs2_i));
`else
  assign raw = match(ex, bus.id_rs1_i) | match(ex, bus.id_rs2_i) |
               match(mem, bus.id_rs1_i) | match(mem, bus.id_rs2_i) |
               match(wb, bus.id_rs1_i) | match(wb, bus.id_rs2_i);
`endif
  always_comb begin
    hazard = bus.id_valid_i & raw;
    adv    = ~bus.mem_busy_i;
    issue  = bus.id_valid_i & ~hazard & adv;
    nxt    = (issue && bus.id_rd_i != 5'd0) ? slot_t'({1'b1, bus.id_rd_i, bus.id_mem_re_i}) : '0;
  end
  assign bus.stall_o     = hazard | bus.mem_busy_i;
  assign bus.bubble_o    = hazard & adv;
  assign bus.stall_cnt_o = cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
      cnt <= '0;
    end else begin
      if (adv) begin
        wb  <= mem;
        mem <= ex;
        ex  <= nxt;
      end
      if (bus.stall_o && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
`ifdef FORWARDING_EN
  logic [1:0] fwd_a, fwd_b;
  // EX producer moves to MEM (01), MEM producer moves to WB (10) as the consumer enters EX
  function automatic logic [1:0] src(logic [4:0] rs);
    return match(ex, rs) ? 2'b01 : match(mem, rs) ? 2'b10 : 2'b00;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (adv) begin
      fwd_a <= issue ? src(bus.id_rs1_i) : 2'b00;
      fwd_b <= issue ? src(bus.id_rs2_i) : 2'b00;
    end
  end
  assign bus.fwd_a_o = fwd_a;
  assign bus.fwd_b_o = fwd_b;
`else
  assign bus.fwd_a_o = 2'b00;
  assign bus.fwd_b_o = 2'b00;
`endif
endmodule
